// File: rtl/conv_pkg.sv
// Shared constants, FSM state type and built-in kernel ROM for the convolution
// coefficient loader.
package conv_pkg;

   localparam int NTAPS = 5;
   localparam int CW    = 8;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_VS,
      LOAD,
      COMMIT
   } state_t;

   typedef logic signed [CW-1:0] coef_t;

   // Every kernel sums to 64 so the cascade's >>6 output stage keeps unity gain.
   localparam coef_t KERNEL_ROM [8][NTAPS] = '{
      '{ 8'sd0,   8'sd0,  8'sd64, 8'sd0,   8'sd0  },
      '{ 8'sd16,  8'sd16, 8'sd0,  8'sd16,  8'sd16 },
      '{ 8'sd8,   8'sd16, 8'sd16, 8'sd16,  8'sd8  },
      '{ -8'sd16, 8'sd0,  8'sd96, 8'sd0,   -8'sd16 },
      '{ 8'sd0,   8'sd0,  8'sd64, 8'sd0,   8'sd0  },
      '{ 8'sd0,   8'sd0,  8'sd64, 8'sd0,   8'sd0  },
      '{ 8'sd0,   8'sd0,  8'sd64, 8'sd0,   8'sd0  },
      '{ 8'sd0,   8'sd0,  8'sd64, 8'sd0,   8'sd0  }
   };

endpackage

// File: rtl/sw_sync_debounce.sv
// Two-flop switch synchronizer with an optional stability filter, compiled in
// when SW_DEBOUNCE_EN is defined.
module sw_sync_debounce #(
   parameter int W       = 4,
   parameter int DEB_CYC = 1_000_000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] sync1;
   logic [W-1:0] sync2;

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= d;
         sync2 <= sync1;
      end
   end

`ifdef SW_DEBOUNCE_EN
   localparam int CNTW = $clog2(DEB_CYC + 1);

   logic [CNTW-1:0] cnt;
   logic [W-1:0]    last;

   // Any movement restarts the count; the output follows only a value that
   // has held still for DEB_CYC cycles.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt  <= '0;
         last <= '0;
         q    <= '0;
      end else if (sync2 != last) begin
         last <= sync2;
         cnt  <= '0;
      end else if (cnt != CNTW'(DEB_CYC)) begin
         cnt <= cnt + CNTW'(1);
      end else begin
         q <= last;
      end
   end
`else
   localparam int deb_unused = DEB_CYC;

   assign q = sync2;
`endif

endmodule

// File: rtl/conv_kernel_loader.sv
// Loads one of eight built-in kernels into the 5-tap cascade at a frame
// boundary and commits it atomically. SW_DEBOUNCE_EN enables switch debounce.
module conv_kernel_loader
   import conv_pkg::*;
#(
   parameter int DEB_CYC = 1_000_000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    sw,
   input  logic          vsync,
   input  logic          coef_ready,
   output logic          coef_we,
   output logic [2:0]    coef_addr,
   output logic [CW-1:0] coef_data,
   output logic          commit,
   output logic [2:0]    kernel_id,
   output logic          bypass,
   output logic          busy
);

   localparam logic [2:0] LAST_IDX = 3'(NTAPS - 1);

   state_t     state;
   state_t     next;
   logic [3:0] synced;
   logic [3:0] snap;
   logic       pending;
   logic [2:0] idx;
   logic       vs_prev;
   logic       vs_rise;
   logic       sw_unused;

   assign sw_unused = ^sw[6:3];

   sw_sync_debounce #(
      .W       (4),
      .DEB_CYC (DEB_CYC)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   ({sw[7], sw[2:0]}),
      .q   (synced)
   );

   assign vs_rise = vsync && !vs_prev;
   assign busy    = (state != IDLE) || pending;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next;
      end
   end

   always_comb begin
      next      = state;
      coef_we   = 1'b0;
      coef_addr = '0;
      coef_data = '0;
      commit    = 1'b0;
      case (state)
         IDLE: begin
            if (pending) next = WAIT_VS;
         end
         WAIT_VS: begin
            if (vs_rise) next = LOAD;
         end
         LOAD: begin
            coef_we   = 1'b1;
            coef_addr = idx;
            coef_data = KERNEL_ROM[snap[2:0]][idx];
            if (coef_ready && idx == LAST_IDX) next = COMMIT;
         end
         COMMIT: begin
            commit = 1'b1;
            next   = IDLE;
         end
         default: next = IDLE;
      endcase
   end

   // Pending starts set so the first frame after reset picks up the switches;
   // the snapshot is frozen from the vsync edge until the commit.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pending   <= 1'b1;
         snap      <= '0;
         idx       <= '0;
         vs_prev   <= 1'b0;
         kernel_id <= '0;
         bypass    <= 1'b1;
      end else begin
         vs_prev <= vsync;
         if (state == WAIT_VS && vs_rise) begin
            snap    <= synced;
            pending <= 1'b0;
            idx     <= '0;
         end else if (synced != snap) begin
            pending <= 1'b1;
         end
         if (state == LOAD && coef_ready && idx != LAST_IDX) begin
            idx <= idx + 3'd1;
         end
         if (state == COMMIT) begin
            kernel_id <= snap[2:0];
            bypass    <= ~snap[3];
         end
      end
   end

endmodule

// File: tb/tb_conv_kernel_loader.sv
// Scoreboard bench for conv_kernel_loader: stimulus pushes expected beats and
// commits, a negedge monitor pops and compares them.
module tb_conv_kernel_loader;

`ifdef SW_DEBOUNCE_EN
   localparam int SETTLE = 40;
`else
   localparam int SETTLE = 8;
`endif

   typedef struct {
      int addr;
      int data;
   } beat_t;

   typedef struct {
      int kid;
      int byp;
   } commit_t;

   logic       clk;
   logic       rst;
   logic [7:0] sw;
   logic       vsync;
   logic       coef_ready;
   logic       coef_we;
   logic [2:0] coef_addr;
   logic [7:0] coef_data;
   logic       commit;
   logic [2:0] kernel_id;
   logic       bypass;
   logic       busy;

   int compared = 0;
   int failed   = 0;
   int cyc      = 0;

   beat_t   beatQ[$];
   commit_t commitQ[$];

   int modelSnap    = 0;
   int modelPending = 1;
   int readyMode    = 0;

   int beatsSeen   = 0;
   int commitCount = 0;
   int commitCyc   = 0;
   int vsCyc       = 0;
   bit commitCheck = 0;

   conv_kernel_loader #(
      .DEB_CYC (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sw         (sw),
      .vsync      (vsync),
      .coef_ready (coef_ready),
      .coef_we    (coef_we),
      .coef_addr  (coef_addr),
      .coef_data  (coef_data),
      .commit     (commit),
      .kernel_id  (kernel_id),
      .bypass     (bypass),
      .busy       (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic checkOutput(input string name, input int act, input int req);
      compared++;
      if (act != req) begin
         failed++;
         $display("[TB] FAIL %s: actual %0d required %0d", name, act, req);
      end
   endtask

   task automatic reportFail(input string name, input int act, input int req);
      compared++;
      failed++;
      $display("[TB] FAIL %s: actual %0d required %0d", name, act, req);
   endtask

   // Reference kernels written from the tap tables, not from the RTL ROM.
   function automatic int kernelTap(input int sel, input int tap);
      case (sel)
         1:       return (tap == 2) ? 0 : 16;
         2:       return (tap == 0 || tap == 4) ? 8 : 16;
         3:       return (tap == 2) ? 96 : ((tap == 0 || tap == 4) ? -16 : 0);
         default: return (tap == 2) ? 64 : 0;
      endcase
   endfunction

   function automatic int keyOf(input logic [7:0] s);
      return {28'd0, s[7], s[2:0]};
   endfunction

   task automatic setSw(input logic [7:0] v);
      sw = v;
      if (keyOf(v) != modelSnap) modelPending = 1;
   endtask

   task automatic pushLoad(input logic [7:0] v);
      beat_t   b;
      commit_t c;
      for (int t = 0; t < 5; t++) begin
         b.addr = t;
         b.data = kernelTap(int'(v[2:0]), t);
         beatQ.push_back(b);
      end
      c.kid = int'(v[2:0]);
      c.byp = v[7] ? 0 : 1;
      commitQ.push_back(c);
      modelSnap    = keyOf(v);
      modelPending = 0;
   endtask

   task automatic waitDrain();
      int n = 0;
      while ((beatQ.size() != 0 || commitQ.size() != 0 || commitCheck) && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 400) reportFail("drain_timeout", beatQ.size() + commitQ.size(), 0);
   endtask

   task automatic applyStimulus(input logic [7:0] swv, input int mode, input bit extraVs,
                                input bit doMid, input logic [7:0] midSw);
      bit loadExp;
      readyMode = mode;
      setSw(swv);
      repeat (SETTLE) @(posedge clk);
      #1;
      loadExp = (modelPending != 0);
      if (loadExp) pushLoad(swv);
      vsync = 1'b1;
      vsCyc = cyc;
      @(posedge clk);
      #1;
      vsync = 1'b0;
      if (extraVs) begin
         @(posedge clk);
         #1;
         vsync = 1'b1;
         @(posedge clk);
         #1;
         vsync = 1'b0;
      end
      if (doMid) setSw(midSw);
      waitDrain();
      repeat (SETTLE) @(posedge clk);
      #1;
      if (loadExp && mode == 0 && !extraVs && !doMid)
         checkOutput("vsync_to_commit_cycles", commitCyc - vsCyc + 1, 7);
      checkOutput("busy_after_frame", int'(busy), modelPending);
   endtask

   // Ready driver: 0 = always ready, 1 = random, 2 = repeating 1,0,0,1.
   initial begin
      int phase = 0;
      coef_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (readyMode)
            1:       coef_ready = 1'($urandom_range(0, 1));
            2:       coef_ready = (phase == 0 || phase == 3);
            default: coef_ready = 1'b1;
         endcase
         phase = (phase + 1) % 4;
      end
   end

   // Monitor: pops the scoreboard on each accepted beat and each commit.
   initial begin
      bit      stallValid = 0;
      int      stallAddr  = 0;
      int      stallData  = 0;
      beat_t   b;
      commit_t c;
      forever begin
         @(negedge clk);
         if (!rst) begin
            stallValid  = 0;
            commitCheck = 0;
         end else begin
            if (commitCheck) begin
               commitCheck = 0;
               if (commitQ.size() == 0) begin
                  reportFail("unexpected_commit", int'(kernel_id), -1);
               end else begin
                  c = commitQ.pop_front();
                  checkOutput("kernel_id", int'(kernel_id), c.kid);
                  checkOutput("bypass", int'(bypass), c.byp);
               end
            end
            if (coef_we) begin
               if (stallValid) begin
                  checkOutput("stall_addr_hold", int'(coef_addr), stallAddr);
                  checkOutput("stall_data_hold", int'($signed(coef_data)), stallData);
               end
               if (coef_ready) begin
                  stallValid = 0;
                  beatsSeen++;
                  if (beatQ.size() == 0) begin
                     reportFail("unexpected_beat", int'(coef_addr), -1);
                  end else begin
                     b = beatQ.pop_front();
                     checkOutput("beat_addr", int'(coef_addr), b.addr);
                     checkOutput("beat_data", int'($signed(coef_data)), b.data);
                  end
               end else begin
                  stallValid = 1;
                  stallAddr  = int'(coef_addr);
                  stallData  = int'($signed(coef_data));
               end
            end else if (stallValid) begin
               stallValid = 0;
               reportFail("we_dropped_while_stalled", 0, 1);
            end
            if (commit) begin
               commitCount++;
               commitCyc = cyc;
               checkOutput("beats_left_at_commit", beatQ.size(), 0);
               commitCheck = 1;
            end
         end
      end
   end

   initial begin
      int base;
      int n;
      int commitsBefore;
      logic [7:0] prevSw;
      rst   = 1'b0;
      vsync = 1'b0;
      sw    = 8'h81;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_coef_we", int'(coef_we), 0);
      checkOutput("reset_coef_addr", int'(coef_addr), 0);
      checkOutput("reset_coef_data", int'(coef_data), 0);
      checkOutput("reset_commit", int'(commit), 0);
      checkOutput("reset_kernel_id", int'(kernel_id), 0);
      checkOutput("reset_bypass", int'(bypass), 1);
      checkOutput("reset_busy", int'(busy), 1);
      rst = 1'b1;

      $display("[TB] first load after reset, kernel 1 enabled");
      applyStimulus(8'h81, 0, 0, 0, 8'h00);

      $display("[TB] kernel 3 under 1,0,0,1 backpressure");
      applyStimulus(8'h83, 2, 0, 0, 8'h00);

      $display("[TB] switch change during load");
      applyStimulus(8'h81, 0, 0, 1, 8'h02);
      applyStimulus(8'h02, 0, 0, 0, 8'h00);

      $display("[TB] repeated vsync without switch change");
      applyStimulus(8'h02, 0, 1, 0, 8'h00);
      applyStimulus(8'h7A, 0, 0, 0, 8'h00);

      $display("[TB] reset during load");
      readyMode = 0;
      setSw(8'h83);
      repeat (SETTLE) @(posedge clk);
      #1;
      pushLoad(8'h83);
      base  = beatsSeen;
      vsync = 1'b1;
      @(posedge clk);
      #1;
      vsync = 1'b0;
      n = 0;
      while (beatsSeen < base + 2 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 50) reportFail("reset_test_beat_timeout", beatsSeen - base, 2);
      rst = 1'b0;
      beatQ.delete();
      commitQ.delete();
      modelPending  = 1;
      modelSnap     = 0;
      commitsBefore = commitCount;
      @(posedge clk);
      #1;
      checkOutput("abort_coef_we", int'(coef_we), 0);
      checkOutput("abort_commit", int'(commit), 0);
      checkOutput("abort_kernel_id", int'(kernel_id), 0);
      checkOutput("abort_bypass", int'(bypass), 1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("abort_no_commit", commitCount, commitsBefore);
      applyStimulus(8'h83, 1, 0, 0, 8'h00);

`ifdef SW_DEBOUNCE_EN
      $display("[TB] debounce glitch filtering");
      applyStimulus(8'h02, 0, 0, 0, 8'h00);
      sw = 8'h03;
      repeat (10) @(posedge clk);
      #1;
      sw = 8'h02;
      repeat (SETTLE) @(posedge clk);
      #1;
      checkOutput("glitch_busy", int'(busy), 0);
      setSw(8'h03);
      repeat (SETTLE) @(posedge clk);
      #1;
      checkOutput("held_change_busy", int'(busy), 1);
      applyStimulus(8'h03, 0, 0, 0, 8'h00);
`endif

      $display("[TB] randomized frames");
      prevSw = sw;
      for (int i = 0; i < 16; i++) begin
         logic [7:0] v;
         logic [7:0] m;
         v = ($urandom_range(0, 3) == 0) ? prevSw : 8'($urandom);
         m = 8'($urandom);
         applyStimulus(v, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) == 0), m);
         prevSw = sw;
      end

      checkOutput("final_beats_left", beatQ.size(), 0);
      checkOutput("final_commits_left", commitQ.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule

// File: doc/conv_kernel_loader.md
# conv_kernel_loader

Coefficient sequencer for the HDMI convolution filter's 5-tap DSP cascade. It watches the user switches, selects one of eight built-in kernels, and waits for a frame boundary (vsync). It then writes the five coefficients into the cascade over a valid/ready write port and commits them atomically, so a kernel never changes mid-frame.

## Interface
- `NTAPS`, 5, number of cascade taps / coefficients per kernel
- `CW`, 8, coefficient width (signed two's complement)
- `DEB_CYC`, 1_000_000, debounce stable-time in clk cycles (used only with debounce compiled in)
- `clk` in 1: pixel clock; all logic on rising edge
- `rst` in 1: synchronous, active-low reset
- `sw` in 8: user switches; sw[7] = filter enable, sw[2:0] = kernel select, sw[6:3] ignored
- `vsync` in 1: frame sync from timing generator, synchronous to clk, active high
- `coef_ready` in 1: cascade can accept a coefficient write this cycle
- `coef_we` out 1: coefficient write valid
- `coef_addr` out 3: tap index 0..NTAPS-1
- `coef_data` out CW: coefficient value
- `commit` out 1: one-cycle pulse; cascade swaps shadow coefficients into its active set
- `kernel_id` out 3: kernel currently committed
- `bypass` out 1: 1 = cascade passes the centre pixel unfiltered
- `busy` out 1: a load is pending or in progress

## Operation
- sw passes through a 2-flop synchronizer. A change in synced {sw[7], sw[2:0]} versus the last snapshot sets `pending`.
- vsync rising edge is detected with one register (previous-vsync flop).
- FSM states: IDLE, WAIT_VS, LOAD, COMMIT.
  - IDLE: if `pending`, go to WAIT_VS.
  - WAIT_VS: on a vsync rising edge, snapshot sel = sw[2:0] and en = sw[7], clear `pending`, set idx = 0, go to LOAD.
  - LOAD: drive coef_we = 1, coef_addr = idx, coef_data = ROM[sel][idx]. A beat is accepted when coef_we && coef_ready. On an accepted beat with idx = NTAPS-1, go to COMMIT; otherwise idx increments.
  - COMMIT: assert commit for one cycle; kernel_id <= sel; bypass <= ~en; go to IDLE.
- While coef_ready is low, coef_we, coef_addr and coef_data hold stable.
- Kernel ROM (taps 0..4, signed, each kernel sums to 64 = unity gain at >>6):
  - Kernel 0: 0,0,64,0,0
  - Kernel 1: 16,16,0,16,16
  - Kernel 2: 8,16,16,16,8
  - Kernel 3: -16,0,96,0,-16
  - Kernels 4..7: identical to kernel 0
- busy = (state != IDLE) || pending.

## Timing
- Reset values: coef_we 0, coef_addr 0, coef_data 0, commit 0, kernel_id 0, bypass 1. `pending` resets to 1 and the snapshot to 0, so the first vsync after reset loads the current switch setting.
- Switch-to-pending latency: 3 cycles (2 sync + 1 compare), without debounce.
- LOAD lasts NTAPS cycles when coef_ready is held high. commit asserts in the cycle after the last accepted beat.
- Total latency from vsync rise to the commit pulse is 7 cycles, with coef_ready high:
  - 1 cycle edge detect
  - 5 cycles LOAD
  - 1 cycle COMMIT
- A switch change during WAIT_VS updates nothing; the snapshot is taken at the vsync edge. A change during LOAD or COMMIT sets `pending`. The current load finishes with its old snapshot, and a second load follows at the next vsync.
- Extra vsync edges during LOAD or COMMIT are ignored.
- A change that reverts before vsync still reloads; the result is the same kernel and is harmless.
- Reset asserted mid-load aborts the load immediately, with no commit. All outputs return to reset values.

## Configuration
- `SW_DEBOUNCE_EN`: when defined, the synced switch vector must remain unchanged for DEB_CYC consecutive cycles before it is compared against the snapshot. Any change restarts the counter, and the counter is ceil(log2(DEB_CYC+1)) bits wide. When undefined, there is no counter and the synced value is compared directly; DEB_CYC is unused.

## Structure
- Shared package `conv_pkg`:
  - NTAPS and CW constants
  - FSM state enum (IDLE, WAIT_VS, LOAD, COMMIT)
  - kernel ROM constant array
- One sub-module, `sw_sync_debounce`: 2-flop synchronizer plus the optional debounce counter (guarded by SW_DEBOUNCE_EN), parameterized on width (4) and DEB_CYC.

## Test plan
- Reset release with sw=8'h81, coef_ready=1, vsync pulse:
  - 5 writes: addr 0..4, data 16,16,0,16,16
  - commit 7 cycles after the vsync rise
  - kernel_id=1, bypass=0
- Backpressure: coef_ready toggles 1,0,0,1,… during a kernel-3 load:
  - data/addr stay stable while ready is low
  - data sequence is F0,00,60,00,F0 hex
  - exactly 5 accepted beats, one commit
- sw change 8'h81 -> 8'h02 during LOAD:
  - first load completes with kernel 1
  - busy stays 1
  - next vsync loads kernel 2, with kernel_id=2 and bypass=1
- No switch change, repeated vsync pulses: coef_we never asserts; busy=0.
- rst low at LOAD beat 2:
  - coef_we drops next cycle, no commit, kernel_id=0
  - after release, the next vsync performs a full 5-beat load
- With SW_DEBOUNCE_EN and DEB_CYC=16, a glitch on sw[0] for 10 cycles then reverting leaves pending=0 and busy=0; holding the change for 20 cycles sets busy.
